// File: rtl/template_pkg.sv
// Shared constants and helpers for the template input stage.
package template_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  localparam int unsigned STALL_W   = 8;
  localparam logic [STALL_W-1:0] STALL_MAX = 8'hFF;

  // Pointer width for a power-of-two depth (at least 1 bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/template_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, asynchronous read.
module template_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AW         = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/template_in_fifo.sv
// First-word-fall-through elastic buffer ahead of the template data stage.
module template_in_fifo
  import template_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned AW        = ptr_width(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [AW:0]           o_count,
  output logic [STALL_W-1:0]    o_stall_cnt
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [AW:0]           count;
  logic [STALL_W-1:0]    stall_cnt;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] rdata;

  // Handshake is derived from the explicit count only (no pass-through when full).
  always_comb begin
    o_ready     = (count != FULL_CNT);
    o_valid     = (count != '0);
    push        = i_valid & o_ready;
    pop         = o_valid & i_ready;
    o_data      = o_valid ? rdata : '0;
    o_count     = count;
    o_stall_cnt = stall_cnt;
  end

  template_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (i_clk),
    .we    (push & ~i_clear),
    .waddr (wr_ptr),
    .wdata (i_data),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Pointer and occupancy update; a clear overrides any push or pop this cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (i_clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating count of cycles where upstream offered a word that was refused.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt <= '0;
    end else if (i_valid && !o_ready && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_template_in_fifo.sv
// Self-checking bench for template_in_fifo against a queue-based reference model.
module tb_template_in_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_clear = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_data = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [DW-1:0] o_data;
  logic [AW:0]   o_count;
  logic [7:0]    o_stall_cnt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [DW-1:0] q[$];
  int unsigned   m_stall = 0;

  template_in_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (i_clear),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_count     (o_count),
    .o_stall_cnt (o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_data;
    exp_data = (q.size() != 0) ? 32'(q[0]) : 32'h0;
    check({tag, ".ready"}, 32'(o_ready), 32'(q.size() != DEPTH));
    check({tag, ".valid"}, 32'(o_valid), 32'(q.size() != 0));
    check({tag, ".data"},  32'(o_data),  exp_data);
    check({tag, ".count"}, 32'(o_count), 32'(q.size()));
    check({tag, ".stall"}, 32'(o_stall_cnt), 32'(m_stall));
  endtask

  // Advance one clock, updating the model from the inputs held across the edge.
  task automatic tick(input string tag);
    bit rdy, vld, do_push, do_pop;
    rdy     = (q.size() != DEPTH);
    vld     = (q.size() != 0);
    do_push = i_valid && rdy;
    do_pop  = vld && i_ready;
    if (i_valid && !rdy && m_stall < 255) m_stall++;
    if (i_clear) begin
      q.delete();
    end else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(i_data);
    end
    @(posedge i_clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset then idle
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    check_all("reset");
    check("reset.ready_const", 32'(o_ready), 32'd1);
    tick("idle");

    // Three pushes with downstream stalled, then drain
    i_valid = 1'b1;
    i_data = 8'hA1; tick("push_a1");
    check("a1_fwft", 32'(o_data), 32'hA1);
    i_data = 8'hB2; tick("push_b2");
    i_data = 8'hC3; tick("push_c3");
    check("count3", 32'(o_count), 32'd3);
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick("pop_a1");
    check("head_b2", 32'(o_data), 32'hB2);
    tick("pop_b2");
    tick("pop_c3");
    check("empty_data0", 32'(o_data), 32'h0);
    i_ready = 1'b0;

    // Fill, then offer 0x14 while full for three cycles
    i_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_data = 8'(8'h10 + k);
      tick("fill");
    end
    i_data = 8'h14;
    repeat (3) tick("full_offer");
    check("full_ready0", 32'(o_ready), 32'd0);
    check("stall3", 32'(o_stall_cnt), 32'd3);
    check("head_10", 32'(o_data), 32'h10);
    i_ready = 1'b1;
    tick("pop_while_full");
    i_ready = 1'b0;
    tick("accept_14");
    check("refull_count4", 32'(o_count), 32'd4);
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (4) tick("drain");
    i_ready = 1'b0;

    // Continuous push/pop across pointer wrap
    i_valid = 1'b1;
    i_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      i_data = 8'(k);
      tick("stream");
      check("stream_count1", 32'(o_count), 32'd1);
      check("stream_data", 32'(o_data), 32'(k));
    end
    i_valid = 1'b0;
    tick("stream_drain");

    // Clear together with a push
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data = 8'h55; tick("pre_clr0");
    i_data = 8'h66; tick("pre_clr1");
    i_data = 8'hEE;
    i_clear = 1'b1;
    tick("clear");
    check("clear_count0", 32'(o_count), 32'd0);
    check("clear_valid0", 32'(o_valid), 32'd0);
    i_clear = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (2) begin
      tick("post_clear");
      check("no_ee", 32'(o_data != 8'hEE), 32'd1);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_ready = 1'($urandom_range(0, 2) != 0);
      i_data  = 8'($urandom);
      i_clear = 1'($urandom_range(0, 31) == 0);
      tick("random");
    end
    i_clear = 1'b0;

    // Hold full with offered data until the stall counter saturates
    i_ready = 1'b0;
    i_valid = 1'b1;
    for (int n = 0; n < 300 + DEPTH; n++) begin
      i_data = 8'($urandom);
      tick("saturate");
    end
    check("stall_sat", 32'(o_stall_cnt), 32'd255);

    // Asynchronous reset mid-cycle
    #3;
    i_reset = 1'b1;
    #1;
    q.delete();
    m_stall = 0;
    check("arst.ready", 32'(o_ready), 32'd1);
    check("arst.valid", 32'(o_valid), 32'd0);
    check("arst.data", 32'(o_data), 32'd0);
    check("arst.count", 32'(o_count), 32'd0);
    check("arst.stall", 32'(o_stall_cnt), 32'd0);
    #2;
    i_reset = 1'b0;
    i_valid = 1'b1;
    i_data = 8'h3C;
    tick("post_reset_push");
    check("post_reset_head", 32'(o_data), 32'h3C);
    i_valid = 1'b0;
    tick("post_reset_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/template_in_fifo.md
Name: template_in_fifo

Overview:
Elastic input buffer directly upstream of the template data stage; absorbs a bursty valid/ready byte stream and presents it, in order, to the template i_data path.
- First-word-fall-through synchronous FIFO with depth-parameterised storage, occupancy count and a saturating stall counter.
- Deterministic, all-zero outputs when empty, so mutation miters built on this stage compare cleanly.

Parameters:
DATA_WIDTH, 8, width of each stored word (matches template i_data)
DEPTH, 4, number of entries; power of two, >= 2
AW, $clog2(DEPTH), derived pointer width; not overridden by instantiators

Ports:
i_clk  input  1  single clock, all state on rising edge
i_reset  input  1  asynchronous, active-high reset
i_clear  input  1  synchronous flush; empties FIFO, keeps stall counter
i_valid  input  1  upstream word valid
o_ready  output  1  FIFO can accept a word this cycle
i_data  input  DATA_WIDTH  upstream word
o_valid  output  1  head word valid
i_ready  input  1  downstream (template stage) accepts head word
o_data  output  DATA_WIDTH  head word; 0 when o_valid=0
o_count  output  AW+1  current occupancy, 0..DEPTH
o_stall_cnt  output  8  saturating count of cycles with i_valid=1 and o_ready=0

Behaviour:
- Reset (i_reset=1, any time, asynchronous):
  - rd_ptr, wr_ptr, count and stall counter go to 0.
  - o_valid=0, o_ready=1, o_data=0, o_count=0, o_stall_cnt=0.
  - Storage contents are not reset.
- Handshake:
  - push = i_valid & o_ready; pop = o_valid & i_ready.
  - o_ready = (count != DEPTH). Combinational from count only; no pass-through when full.
  - o_valid = (count != 0).
- FWFT: o_data = mem[rd_ptr] when o_valid, else 0. A word pushed in cycle N is visible on o_data/o_valid in cycle N+1, giving 1-cycle latency when empty.
- Push: mem[wr_ptr] <= i_data; wr_ptr <= wr_ptr+1, wrapping mod DEPTH.
- Pop: rd_ptr <= rd_ptr+1, wrapping mod DEPTH.
- Count update:
  - push only: +1
  - pop only: -1
  - push & pop: unchanged, both pointers advance
  - neither: hold
- Full with i_ready=1: the pop happens, o_ready is 0 this cycle, so no push; o_ready rises next cycle.
- Empty with i_valid=1: push only; pop is impossible because o_valid=0.
- i_clear=1:
  - Next cycle rd_ptr=wr_ptr=0 and count=0.
  - Overrides any push or pop in that cycle; the word offered is dropped and o_ready stays as computed.
  - Stall counter unaffected.
- Stall counter:
  - Increments when i_valid & !o_ready.
  - Saturates at 255, never wraps.
  - Cleared only by i_reset.
- Invariants:
  - count == (wr_ptr - rd_ptr) mod DEPTH, or DEPTH when pointers are equal and full.
  - Count kept explicitly (AW+1 bits), not inferred from pointers.
  - No overflow or underflow is possible: writes are gated by o_ready, reads by o_valid.
- Reset mid-burst: all in-flight words are lost. Output is empty the cycle after reset is released and only new pushes appear.

Decomposition:
- Package template_pkg:
  - DATA_WIDTH default (8)
  - stall counter width (8) and saturation constant (8'hFF)
  - pointer-width helper function
- Sub-module template_fifo_mem:
  - DEPTH x DATA_WIDTH register array
  - one write port (we, waddr, wdata), asynchronous read port (raddr, rdata)
  - no reset
- Top: pointers, count, handshake, zero-masking of o_data, stall counter.

Test Plan:
- Reset then idle: o_ready=1, o_valid=0, o_data=0, o_count=0, o_stall_cnt=0.
- Push 8'hA1, 8'hB2, 8'hC3 with i_ready=0 → o_count=3; o_data=8'hA1 one cycle after first push. Raise i_ready → reads A1, B2, C3 on consecutive cycles, then o_valid=0 and o_data=0.
- Fill DEPTH=4 (8'h10..8'h13), hold i_valid=1 with 8'h14 for 3 cycles, i_ready=0 → o_ready=0, o_count=4, o_stall_cnt=3. Then one pop → 8'h10 out, 8'h14 accepted the following cycle, o_count back to 4.
- Continuous push and pop, 10 words (8'h00..8'h09) across pointer wrap → outputs in order, o_count constant at 1, no stall.
- Push 2 words, assert i_clear together with a push of 8'hEE → next cycle o_count=0, o_valid=0; 8'hEE never appears on o_data.
- Hold full with i_valid=1 for 300 cycles → o_stall_cnt=255. Then i_reset pulsed mid-cycle (asynchronous) → all outputs at reset values immediately.
